// File: rtl/conv_encoder_framer_if.sv
// Framer <-> stimulus/decoder signal bundle: frame request inputs plus every decoder control output.
// master drives frame requests; slave is the framer that programs and feeds the decoder.
interface conv_encoder_framer_if #(
   parameter int n = 2,
   parameter int k = 1,
   parameter int m = 4,
   parameter int L = 7
);
   localparam int E = $clog2(L * n);

   logic             start;
   logic             reload;
   logic [0:k*L-1]   message;
   logic [0:L*n-1]   err_mask;
   logic             busy;
   logic             done;
   logic [E:0]       inj_errors;
   logic             load;
   logic [0:m-k-1]   state_address;
   logic [0:k-1]     input_address;
   logic [0:m-k-1]   next_state_data;
   logic [0:n-1]     output_data;
   logic             restart;
   logic             enable;
   logic [0:n-1]     encoded;

   modport master (
      output start, reload, message, err_mask,
      input  busy, done, inj_errors, load, state_address, input_address,
             next_state_data, output_data, restart, enable, encoded
   );

   modport slave (
      input  start, reload, message, err_mask,
      output busy, done, inj_errors, load, state_address, input_address,
             next_state_data, output_data, restart, enable, encoded
   );
endinterface

// File: rtl/conv_encoder_framer.sv
// Programs the decoder trellis tables, then streams one encoded, error-masked frame of L steps.
// First symbol 2**m+2 cycles after start with a table load, 2 without; no backpressure, start ignored while busy.
module conv_encoder_framer #(
   parameter int             n = 2,
   parameter int             k = 1,
   parameter int             m = 4,
   parameter int             L = 7,
   parameter logic [n*m-1:0] G = 8'b1111_1101,
   parameter int             E = $clog2(L * n)
) (
   input  logic                  clk,
   input  logic                  reset,
   conv_encoder_framer_if.slave  bus
);
   localparam int SW = m - k;
   localparam int NE = 2 ** m;
   localparam int CW = $clog2((NE > L) ? NE : L);
   localparam int EW = E + 1;
   localparam logic [CW-1:0] LAST_E = CW'(NE - 1);
   localparam logic [CW-1:0] LAST_S = CW'(L - 1);

   typedef enum logic [2:0] {IDLE, LOAD, RST, STREAM, FIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [0:SW-1]    enc_q, enc_d;
   logic             loaded_q, loaded_d;
   logic [0:k*L-1]   msg_q, msg_d;
   logic [0:L*n-1]   mask_q, mask_d;
   logic [E:0]       inj_q, inj_d;

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_q, load_d;
   logic [0:SW-1]    sa_q, sa_d;
   logic [0:k-1]     ia_q, ia_d;
   logic [0:SW-1]    ns_q, ns_d;
   logic [0:n-1]     od_q, od_d;
   logic             restart_q, restart_d;
   logic             enable_q, enable_d;
   logic [0:n-1]     encoded_q, encoded_d;

   // Shift register view r = {input, state}; next state keeps the leading m-k bits of r.
   function automatic logic [0:SW-1] enc_next(input logic [0:k-1] in_bits, input logic [0:SW-1] st);
      return SW'({in_bits, st} >> k);
   endfunction

   function automatic logic [0:n-1] enc_out(input logic [0:k-1] in_bits, input logic [0:SW-1] st);
      logic [0:m-1] r;
      logic [0:n-1] o;
      r = {in_bits, st};
      for (int j = 0; j < n; j++) o[j] = ^(r & G[n*m-1-j*m -: m]);
      return o;
   endfunction

   function automatic logic [E:0] popcount(input logic [0:L*n-1] v);
      logic [E:0] c;
      c = '0;
      for (int i = 0; i < L * n; i++) c = c + EW'(v[i]);
      return c;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      enc_d    = enc_q;
      loaded_d = loaded_q;
      msg_d    = msg_q;
      mask_d   = mask_q;
      inj_d    = inj_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               msg_d   = bus.message;
               mask_d  = bus.err_mask;
               inj_d   = popcount(bus.err_mask);
               cnt_d   = '0;
               enc_d   = '0;
               state_d = (bus.reload || !loaded_q) ? LOAD : RST;
            end
         end
         LOAD: begin
            if (cnt_q == LAST_E) begin
               cnt_d    = '0;
               loaded_d = 1'b1;
               state_d  = RST;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RST: begin
            cnt_d   = '0;
            state_d = STREAM;
         end
         STREAM: begin
            enc_d = enc_next(msg_q[int'(cnt_q)*k +: k], enc_q);
            if (cnt_q == LAST_S) begin
               cnt_d   = '0;
               state_d = FIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         FIN: begin
            enc_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the upcoming state so they are registered yet aligned to it.
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == FIN);
      load_d    = (state_d == LOAD);
      restart_d = (state_d == RST);
      enable_d  = (state_d == STREAM);
      sa_d      = '0;
      ia_d      = '0;
      ns_d      = '0;
      od_d      = '0;
      encoded_d = '0;
      if (load_d) begin
         sa_d = cnt_d[m-1:k];
         ia_d = cnt_d[k-1:0];
         ns_d = enc_next(ia_d, sa_d);
         od_d = enc_out(ia_d, sa_d);
      end
      if (enable_d) begin
         encoded_d = enc_out(msg_d[int'(cnt_d)*k +: k], enc_d) ^ mask_d[int'(cnt_d)*n +: n];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         enc_q     <= '0;
         loaded_q  <= 1'b0;
         msg_q     <= '0;
         mask_q    <= '0;
         inj_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         load_q    <= 1'b0;
         sa_q      <= '0;
         ia_q      <= '0;
         ns_q      <= '0;
         od_q      <= '0;
         restart_q <= 1'b0;
         enable_q  <= 1'b0;
         encoded_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         enc_q     <= enc_d;
         loaded_q  <= loaded_d;
         msg_q     <= msg_d;
         mask_q    <= mask_d;
         inj_q     <= inj_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         load_q    <= load_d;
         sa_q      <= sa_d;
         ia_q      <= ia_d;
         ns_q      <= ns_d;
         od_q      <= od_d;
         restart_q <= restart_d;
         enable_q  <= enable_d;
         encoded_q <= encoded_d;
      end
   end

   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.inj_errors      = inj_q;
   assign bus.load            = load_q;
   assign bus.state_address   = sa_q;
   assign bus.input_address   = ia_q;
   assign bus.next_state_data = ns_q;
   assign bus.output_data     = od_q;
   assign bus.restart         = restart_q;
   assign bus.enable          = enable_q;
   assign bus.encoded         = encoded_q;
endmodule

// File: tb/tb_conv_encoder_framer.sv
// Bench for conv_encoder_framer: directed frames plus random frames checked against an arithmetic
// shift-register model of the rate-1/2, m=4 encoder.
module tb_conv_encoder_framer;
   localparam int N  = 2;
   localparam int M  = 4;
   localparam int GV = 'hFD;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   conv_encoder_framer_if bus ();
   conv_encoder_framer dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad = 0;

   logic [7:0] ld_r [0:39];
   logic [7:0] sa_r [0:39];
   logic [7:0] ia_r [0:39];
   logic [7:0] ns_r [0:39];
   logic [7:0] od_r [0:39];
   logic [7:0] rs_r [0:39];
   logic [7:0] en_r [0:39];
   logic [7:0] enc_r [0:39];
   logic [7:0] dn_r [0:39];
   logic [7:0] busy_r [0:39];
   logic [7:0] inj_r [0:39];

   // Symbol for shift-register value r (bit m-1 holds the newest input); output bit 0 is the MSB.
   function automatic int sym_of(input int r);
      int sym = 0;
      for (int j = 0; j < N; j++) begin
         int tp = (GV >> ((N - 1 - j) * M)) & ((1 << M) - 1);
         sym = (sym << 1) | ($countones(r & tp) & 1);
      end
      return sym;
   endfunction

   function automatic int exp_sym(input logic [0:6] msg, input logic [0:13] mask, input int s);
      int st = 0;
      for (int t = 0; t < 7; t++) begin
         int r = (int'(msg[t]) << (M - 1)) | st;
         if (t == s) return sym_of(r) ^ ((int'(mask[2*t]) << 1) | int'(mask[2*t+1]));
         st = r >> 1;
      end
      return -1;
   endfunction

   function automatic int exp_ns(input int e);
      return (((e & 1) << (M - 1)) | (e >> 1)) >> 1;
   endfunction

   function automatic int exp_od(input int e);
      return sym_of(((e & 1) << (M - 1)) | (e >> 1));
   endfunction

   task automatic kick(input logic [0:6] msg, input logic [0:13] mask, input logic rl);
      @(negedge clk);
      bus.message  = msg;
      bus.err_mask = mask;
      bus.reload   = rl;
      bus.start    = 1'b1;
   endtask

   // Records ncyc cycles after the start edge; optionally keeps start high with junk inputs, or pulses reset.
   task automatic collect(input int ncyc, input int hold_until, input logic [0:6] alt_msg, input int rst_at);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         ld_r[c]   = 8'(bus.load);
         sa_r[c]   = 8'(bus.state_address);
         ia_r[c]   = 8'(bus.input_address);
         ns_r[c]   = 8'(bus.next_state_data);
         od_r[c]   = 8'(bus.output_data);
         rs_r[c]   = 8'(bus.restart);
         en_r[c]   = 8'(bus.enable);
         enc_r[c]  = 8'(bus.encoded);
         dn_r[c]   = 8'(bus.done);
         busy_r[c] = 8'(bus.busy);
         inj_r[c]  = 8'(bus.inj_errors);
         if (c < hold_until) begin
            bus.start    = 1'b1;
            bus.reload   = 1'b1;
            bus.message  = alt_msg;
            bus.err_mask = 14'($urandom);
         end else begin
            bus.start = 1'b0;
         end
         reset = (c == rst_at);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b1; bus.reload = 1'b1; bus.message = '1; bus.err_mask = '1;
      repeat (3) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
      total++;
      if ({bus.done, bus.load, bus.restart, bus.enable} !== 4'b0000) begin
         bad++; $display("FAIL reset_strobes: got %b want 0000", {bus.done, bus.load, bus.restart, bus.enable});
      end
      total++;
      if (bus.encoded !== 2'b00 || bus.inj_errors !== 5'd0) begin
         bad++; $display("FAIL reset_data: got enc=%b inj=%0d want 0", bus.encoded, bus.inj_errors);
      end
      total++;
      if ({bus.state_address, bus.input_address, bus.next_state_data, bus.output_data} !== 9'd0) begin
         bad++; $display("FAIL reset_table: got %b want 0",
                         {bus.state_address, bus.input_address, bus.next_state_data, bus.output_data});
      end
      reset = 1'b0;
      bus.start = 1'b0; bus.reload = 1'b0; bus.message = '0; bus.err_mask = '0;
      @(negedge clk);
   endtask

   task automatic test_first_frame();
      int exp1 [0:6] = '{3, 3, 2, 3, 0, 0, 0};
      int nload = 0, nrs = 0, ndone = 0, novl = 0;
      kick(7'b1000000, 14'd0, 1'b0);
      collect(30, 0, 7'd0, -1);
      for (int c = 1; c <= 30; c++) begin
         nload += int'(ld_r[c]); nrs += int'(rs_r[c]); ndone += int'(dn_r[c]);
         if (ld_r[c] == 1 && en_r[c] == 1) novl++;
      end
      total++;
      if (nload != 16) begin bad++; $display("FAIL first_load_count: got %0d want 16", nload); end
      for (int e = 0; e < 16; e++) begin
         total++;
         if (ld_r[e+1] !== 8'd1 || sa_r[e+1] !== 8'(e >> 1) || ia_r[e+1] !== 8'(e & 1) ||
             ns_r[e+1] !== 8'(exp_ns(e)) || od_r[e+1] !== 8'(exp_od(e))) begin
            bad++; $display("FAIL load_entry_%0d: got ld=%0d sa=%0d ia=%0d ns=%0d od=%0d want ns=%0d od=%0d",
                            e, ld_r[e+1], sa_r[e+1], ia_r[e+1], ns_r[e+1], od_r[e+1], exp_ns(e), exp_od(e));
         end
      end
      total++;
      if (ns_r[2] !== 8'd4 || od_r[2] !== 8'd3) begin
         bad++; $display("FAIL entry_000_1: got ns=%0d od=%0d want 4 3", ns_r[2], od_r[2]);
      end
      total++;
      if (sa_r[11] !== 8'd5 || ns_r[11] !== 8'd2 || od_r[11] !== 8'd0) begin
         bad++; $display("FAIL entry_101_0: got sa=%0d ns=%0d od=%0d want 5 2 0", sa_r[11], ns_r[11], od_r[11]);
      end
      total++;
      if (ns_r[1] !== 8'd0 || od_r[1] !== 8'd0) begin
         bad++; $display("FAIL entry_000_0: got ns=%0d od=%0d want 0 0", ns_r[1], od_r[1]);
      end
      total++;
      if (rs_r[17] !== 8'd1 || nrs != 1) begin bad++; $display("FAIL first_restart: got %0d x%0d want 1 x1", rs_r[17], nrs); end
      for (int s = 0; s < 7; s++) begin
         total++;
         if (en_r[18+s] !== 8'd1 || enc_r[18+s] !== 8'(exp1[s])) begin
            bad++; $display("FAIL first_sym_%0d: got en=%0d enc=%0d want 1 %0d", s, en_r[18+s], enc_r[18+s], exp1[s]);
         end
      end
      total++;
      if (dn_r[25] !== 8'd1 || ndone != 1) begin bad++; $display("FAIL first_done: got %0d x%0d want 1 x1", dn_r[25], ndone); end
      total++;
      if (inj_r[25] !== 8'd0) begin bad++; $display("FAIL first_inj: got %0d want 0", inj_r[25]); end
      total++;
      if (novl != 0 || busy_r[26] !== 8'd0) begin
         bad++; $display("FAIL first_tail: got overlap=%0d busy=%0d want 0 0", novl, busy_r[26]);
      end
   endtask

   task automatic test_no_reload();
      int exp3 [0:6] = '{2, 3, 2, 3, 0, 0, 0};
      int nload = 0, ndone = 0;
      kick(7'b1000000, 14'b01_0000_0000_0000, 1'b0);
      collect(30, 0, 7'd0, -1);
      for (int c = 1; c <= 30; c++) begin nload += int'(ld_r[c]); ndone += int'(dn_r[c]); end
      total++;
      if (nload != 0 || rs_r[1] !== 8'd1) begin bad++; $display("FAIL noreload_start: got loads=%0d rs=%0d want 0 1", nload, rs_r[1]); end
      for (int s = 0; s < 7; s++) begin
         total++;
         if (en_r[2+s] !== 8'd1 || enc_r[2+s] !== 8'(exp3[s])) begin
            bad++; $display("FAIL noreload_sym_%0d: got en=%0d enc=%0d want 1 %0d", s, en_r[2+s], enc_r[2+s], exp3[s]);
         end
      end
      total++;
      if (dn_r[9] !== 8'd1 || ndone != 1 || inj_r[9] !== 8'd1) begin
         bad++; $display("FAIL noreload_done: got done=%0d x%0d inj=%0d want 1 x1 1", dn_r[9], ndone, inj_r[9]);
      end
   endtask

   task automatic test_start_held();
      int exp1 [0:6] = '{3, 3, 2, 3, 0, 0, 0};
      int nload = 0, ndone = 0, nbusy_late = 0, ninj = 0;
      kick(7'b1000000, 14'd0, 1'b0);
      collect(30, 9, 7'($urandom), -1);
      for (int c = 1; c <= 30; c++) begin
         nload += int'(ld_r[c]); ndone += int'(dn_r[c]);
         if (c >= 10) nbusy_late += int'(busy_r[c]);
         if (inj_r[c] !== 8'd0) ninj++;
      end
      total++;
      if (nload != 0 || ndone != 1) begin bad++; $display("FAIL held_counts: got loads=%0d dones=%0d want 0 1", nload, ndone); end
      for (int s = 0; s < 7; s++) begin
         total++;
         if (enc_r[2+s] !== 8'(exp1[s])) begin
            bad++; $display("FAIL held_sym_%0d: got %0d want %0d", s, enc_r[2+s], exp1[s]);
         end
      end
      total++;
      if (nbusy_late != 0 || ninj != 0) begin
         bad++; $display("FAIL held_tail: got late_busy=%0d inj_changes=%0d want 0 0", nbusy_late, ninj);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [0:6] msg;
      logic [0:13] mask;
      int ndone = 0, nbusy = 0, nload = 0;
      msg = 7'($urandom);
      mask = '0;
      mask[$urandom_range(0, 13)] = 1'b1;
      kick(msg, mask, 1'b1);
      collect(30, 0, 7'd0, 6);
      for (int c = 1; c <= 30; c++) begin
         ndone += int'(dn_r[c]);
         if (c >= 7) nbusy += int'(busy_r[c]);
      end
      total++;
      if (ld_r[6] !== 8'd1 || sa_r[6] !== 8'd2 || ia_r[6] !== 8'd1) begin
         bad++; $display("FAIL abort_entry5: got ld=%0d sa=%0d ia=%0d want 1 2 1", ld_r[6], sa_r[6], ia_r[6]);
      end
      total++;
      if ({ld_r[7], sa_r[7], ia_r[7], ns_r[7], od_r[7], rs_r[7], en_r[7], enc_r[7], dn_r[7], busy_r[7], inj_r[7]} !== 88'd0) begin
         bad++; $display("FAIL abort_zero: got ld=%0d sa=%0d ns=%0d od=%0d busy=%0d inj=%0d want all 0",
                         ld_r[7], sa_r[7], ns_r[7], od_r[7], busy_r[7], inj_r[7]);
      end
      total++;
      if (ndone != 0 || nbusy != 0) begin bad++; $display("FAIL abort_quiet: got dones=%0d busy=%0d want 0 0", ndone, nbusy); end
      kick(msg, mask, 1'b0);
      collect(30, 0, 7'd0, -1);
      for (int c = 1; c <= 30; c++) nload += int'(ld_r[c]);
      total++;
      if (nload != 16) begin bad++; $display("FAIL abort_reload: got loads=%0d want 16", nload); end
      for (int s = 0; s < 7; s++) begin
         total++;
         if (enc_r[18+s] !== 8'(exp_sym(msg, mask, s))) begin
            bad++; $display("FAIL abort_sym_%0d: got %0d want %0d", s, enc_r[18+s], exp_sym(msg, mask, s));
         end
      end
      total++;
      if (dn_r[25] !== 8'd1 || inj_r[25] !== 8'd1) begin
         bad++; $display("FAIL abort_done: got done=%0d inj=%0d want 1 1", dn_r[25], inj_r[25]);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 24; it++) begin
         logic [0:6] msg;
         logic [0:13] mask;
         logic rl;
         int base, nload, ndone, viol, nsym_bad, ntbl_bad, sel;
         msg = 7'($urandom);
         rl = 1'($urandom);
         sel = $urandom_range(0, 2);
         mask = '0;
         if (sel == 1) mask[$urandom_range(0, 13)] = 1'b1;
         else if (sel == 2) mask = 14'($urandom);
         kick(msg, mask, rl);
         collect(30, 0, 7'd0, -1);
         base = rl ? 17 : 1;
         nload = 0; ndone = 0; viol = 0; nsym_bad = 0; ntbl_bad = 0;
         for (int c = 1; c <= 30; c++) begin
            nload += int'(ld_r[c]); ndone += int'(dn_r[c]);
            if (ld_r[c] == 0 && {sa_r[c], ia_r[c], ns_r[c], od_r[c]} != 32'd0) viol++;
            if (en_r[c] == 0 && enc_r[c] != 0) viol++;
            if (ld_r[c] == 1 && en_r[c] == 1) viol++;
         end
         if (rl) begin
            for (int e = 0; e < 16; e++)
               if (ns_r[e+1] !== 8'(exp_ns(e)) || od_r[e+1] !== 8'(exp_od(e)) || sa_r[e+1] !== 8'(e >> 1)) ntbl_bad++;
         end
         for (int s = 0; s < 7; s++)
            if (en_r[base+1+s] !== 8'd1 || enc_r[base+1+s] !== 8'(exp_sym(msg, mask, s))) nsym_bad++;
         total++;
         if (nload != (rl ? 16 : 0) || rs_r[base] !== 8'd1 || ntbl_bad != 0) begin
            bad++; $display("FAIL rand_%0d_load: got loads=%0d rs=%0d tbl_bad=%0d reload=%0b", it, nload, rs_r[base], ntbl_bad, rl);
         end
         total++;
         if (nsym_bad != 0) begin
            bad++; $display("FAIL rand_%0d_stream: got %0d bad symbols want 0 (msg=%b mask=%b)", it, nsym_bad, msg, mask);
         end
         total++;
         if (dn_r[base+8] !== 8'd1 || ndone != 1 || inj_r[base+8] !== 8'($countones(mask))) begin
            bad++; $display("FAIL rand_%0d_done: got done=%0d x%0d inj=%0d want 1 x1 %0d",
                            it, dn_r[base+8], ndone, inj_r[base+8], $countones(mask));
         end
         total++;
         if (viol != 0) begin bad++; $display("FAIL rand_%0d_idle_outputs: got %0d violations want 0", it, viol); end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.reload = 1'b0; bus.message = '0; bus.err_mask = '0;
      test_reset();
      test_first_frame();
      test_no_reload();
      test_start_held();
      test_reset_mid_load();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
